bsg_cache_pkt_arb: RTL and testbench

Round-robin arbiter and ordering controller that shares one bsg_cache packet port among `num_req_p` requesters. It issues one packet per handshake and tracks outstanding packets in an in-order requester-ID FIFO. Each cache response is routed back to the requester that issued the matching packet. Maintenance ops (opcode[4]=1) are fenced: the block drains all prior traffic before issuing one, and blocks new issue until its response returns. It sits between the client crossbar and the cache input/output ports.

---
 rtl/bsg_cache_pkt_arb_if.sv | 21 ++
 rtl/bsg_cache_pkt_arb.sv | 83 ++++++++
 tb/tb_bsg_cache_pkt_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bsg_cache_pkt_arb_if.sv
// bsg_cache_pkt_arb_if: requester-side and cache-side handshake bundle for bsg_cache_pkt_arb
interface bsg_cache_pkt_arb_if #(
  parameter int num_req_p = 2,
  parameter int addr_width_p = 39,
  parameter int data_width_p = 64,
  parameter int pkt_width_lp = 5 + addr_width_p + data_width_p + data_width_p/8
);
  logic [num_req_p-1:0] v_i, ready_o, v_o, yumi_i;
  logic [num_req_p*pkt_width_lp-1:0] pkt_i;
  logic cache_v_o, cache_ready_i, cache_v_i, cache_yumi_o;
  logic [pkt_width_lp-1:0] cache_pkt_o;
  logic [data_width_p-1:0] cache_data_i, data_o;
  modport master (
    output v_i, pkt_i, yumi_i, cache_ready_i, cache_v_i, cache_data_i,
    input ready_o, v_o, cache_v_o, cache_pkt_o, cache_yumi_o, data_o
  );
  modport slave (
    input v_i, pkt_i, yumi_i, cache_ready_i, cache_v_i, cache_data_i,
    output ready_o, v_o, cache_v_o, cache_pkt_o, cache_yumi_o, data_o
  );
endinterface

// File: rtl/bsg_cache_pkt_arb.sv
// bsg_cache_pkt_arb: round-robin cache packet arbiter with in-order response routing and maintenance fencing
module bsg_cache_pkt_arb #(
  parameter int num_req_p = 2,
  parameter int addr_width_p = 39,
  parameter int data_width_p = 64,
  parameter int max_out_p = 4,
  localparam int pkt_width_lp = 5 + addr_width_p + data_width_p + data_width_p/8
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_cache_pkt_arb_if.slave bus
);
  localparam int lg_n = $clog2(num_req_p);
  localparam int lg_m = max_out_p > 1 ? $clog2(max_out_p) : 1;
  localparam int cnt_w = $clog2(max_out_p + 1);
  typedef enum logic [1:0] {NORMAL, DRAIN, FENCE} state_e;
  state_e state_q, state_d;
  logic [lg_n-1:0] rr_ptr_q, rr_ptr_d, winner, head;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [lg_m-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [lg_n-1:0] fifo_q [max_out_p];
  logic any_v, maint, issue_en, push, pop, empty, resp_v;
  always_comb begin : sel
    int idx;
    idx = 0;
    winner = rr_ptr_q;
    any_v = 1'b0;
    // scanning downward lets the requester closest to rr_ptr_q win last
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      idx = idx >= num_req_p ? idx - num_req_p : idx;
      if (bus.v_i[idx]) begin
        winner = lg_n'(idx);
        any_v = 1'b1;
      end
    end
  end
  assign bus.cache_pkt_o = bus.pkt_i[winner*pkt_width_lp +: pkt_width_lp];
  assign maint = bus.cache_pkt_o[pkt_width_lp-1];
  assign empty = cnt_q == '0;
  assign issue_en = state_q == NORMAL && cnt_q < cnt_w'(max_out_p) && (!maint || empty);
  assign bus.cache_v_o = reset_n_i & any_v & issue_en;
  assign push = bus.cache_v_o & bus.cache_ready_i;
  assign bus.ready_o = push ? num_req_p'(1) << winner : '0;
  assign head = fifo_q[rd_ptr_q];
  assign resp_v = reset_n_i & bus.cache_v_i & !empty;
  assign bus.v_o = resp_v ? num_req_p'(1) << head : '0;
  assign bus.data_o = bus.cache_data_i;
  assign pop = resp_v & bus.yumi_i[head];
  assign bus.cache_yumi_o = pop;
  always_comb begin
    rr_ptr_d = push ? (winner == lg_n'(num_req_p - 1) ? '0 : winner + 1'b1) : rr_ptr_q;
    wr_ptr_d = push ? (wr_ptr_q == lg_m'(max_out_p - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == lg_m'(max_out_p - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    cnt_d = cnt_q + cnt_w'(push) - cnt_w'(pop);
    state_d = state_q;
    if (state_q == NORMAL)
      state_d = any_v && maint && !empty ? DRAIN : push && maint ? FENCE : NORMAL;
    else if (cnt_d == '0)
      state_d = NORMAL;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= NORMAL;
      rr_ptr_q <= '0;
      cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_n_i && push) fifo_q[wr_ptr_q] <= winner;
  end
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(bus.cache_v_i && empty)) else $error("cache response with no outstanding packet");
  end
endmodule

// File: tb/tb_bsg_cache_pkt_arb.sv
// tb_bsg_cache_pkt_arb: directed scoreboard bench for bsg_cache_pkt_arb
module tb_bsg_cache_pkt_arb;
  localparam int N = 2, AW = 39, DW = 64, M = 4, W = 5 + AW + DW + DW/8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int sb[$];
  logic [W-1:0] pk [N];
  always #5 clk = ~clk;
  bsg_cache_pkt_arb_if #(.num_req_p(N), .addr_width_p(AW), .data_width_p(DW)) bus ();
  bsg_cache_pkt_arb #(.num_req_p(N), .addr_width_p(AW), .data_width_p(DW), .max_out_p(M)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [N-1:0] vv, input logic [4:0] op0, input logic [4:0] op1);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    pk[0] = {op0, r[W-6:0]};
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    pk[1] = {op1, r[W-6:0]};
    bus.v_i = vv;
    for (int k = 0; k < N; k++) bus.pkt_i[k*W +: W] = pk[k];
  endtask
  task automatic resp(input bit valid, input bit yumi);
    bus.cache_v_i = valid;
    bus.cache_data_i = {$urandom(), $urandom()};
    bus.yumi_i = (valid && yumi && sb.size() > 0) ? N'(1) << sb[0] : '0;
  endtask
  // one clock: g is the requester expected to be granted, -1 for no issue
  task automatic cycle(input int g);
    int h;
    @(negedge clk);
    if (bus.cache_v_i) begin
      h = sb[0];
      chk("v_o", bus.v_o, N'(1) << h);
      chk("data_o", bus.data_o, bus.cache_data_i);
      chk("cache_yumi_o", bus.cache_yumi_o, bus.yumi_i[h]);
      if (bus.yumi_i[h]) void'(sb.pop_front());
    end else chk("v_o_idle", bus.v_o, 0);
    chk("cache_v_o", bus.cache_v_o, g >= 0);
    chk("ready_o", bus.ready_o, (g >= 0 && bus.cache_ready_i) ? N'(1) << g : 0);
    if (g >= 0) begin
      chk("cache_pkt_o", bus.cache_pkt_o, pk[g]);
      if (bus.cache_ready_i) sb.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic reset_chk();
    @(negedge clk);
    chk("rst_cache_v_o", bus.cache_v_o, 0);
    chk("rst_ready_o", bus.ready_o, 0);
    chk("rst_v_o", bus.v_o, 0);
    chk("rst_cache_yumi_o", bus.cache_yumi_o, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.cache_ready_i = 1'b1;
    bus.pkt_i = '0;
    req(2'b11, 5'h03, 5'h03);
    bus.cache_v_i = 1'b1;
    bus.cache_data_i = '0;
    bus.yumi_i = '1;
    repeat (2) reset_chk();
    reset_n = 1'b1;
    resp(0, 0);
    chk("cnt_after_reset", dut.cnt_q, 0);
    // grant without cache_ready_i must not advance anything
    bus.cache_ready_i = 1'b0;
    cycle(0);
    bus.cache_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resp(i > 0, 1);
      cycle(i % 2);
    end
    req(2'b00, 5'h03, 5'h03);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    // fill to max_out_p, then consume one and issue alongside the next consume
    req(2'b11, 5'h03, 5'h03);
    for (int i = 0; i < 4; i++) cycle(i % 2);
    cycle(-1);
    chk("cnt_full", dut.cnt_q, 4);
    resp(1, 1);
    cycle(-1);
    resp(1, 1);
    cycle(0);
    chk("cnt_simul", dut.cnt_q, 3);
    req(2'b00, 5'h03, 5'h03);
    for (int i = 0; i < 3; i++) begin
      resp(1, 1);
      cycle(-1);
    end
    resp(0, 0);
    chk("cnt_drained", dut.cnt_q, 0);
    // two stores outstanding, then a flush from requester 1 must drain and fence
    req(2'b01, 5'h0B, 5'h0B);
    cycle(0);
    cycle(0);
    req(2'b11, 5'h03, 5'h14);
    cycle(-1);
    resp(1, 1);
    cycle(-1);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    cycle(1);
    cycle(-1);
    cycle(-1);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    cycle(0);
    req(2'b00, 5'h03, 5'h03);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    // issue 1,0,1 with delayed responses and a stalled consumer on the second
    req(2'b10, 5'h03, 5'h03);
    cycle(1);
    req(2'b01, 5'h03, 5'h03);
    cycle(0);
    req(2'b10, 5'h03, 5'h03);
    cycle(1);
    req(2'b00, 5'h03, 5'h03);
    repeat (2) cycle(-1);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    repeat (2) cycle(-1);
    resp(1, 0);
    cycle(-1);
    resp(1, 0);
    cycle(-1);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    repeat (2) cycle(-1);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    // reset with three packets in flight
    req(2'b11, 5'h03, 5'h03);
    cycle(0);
    cycle(1);
    cycle(0);
    chk("cnt_before_reset", dut.cnt_q, 3);
    reset_n = 1'b0;
    bus.cache_v_i = 1'b1;
    bus.yumi_i = '1;
    reset_chk();
    reset_n = 1'b1;
    resp(0, 0);
    sb.delete();
    chk("cnt_mid_reset", dut.cnt_q, 0);
    cycle(0);
    req(2'b00, 5'h03, 5'h03);
    resp(1, 1);
    cycle(-1);
    resp(0, 0);
    chk("cnt_end", dut.cnt_q, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
